fifo_in_unpack: RTL and testbench

- Read-side counterpart of the maxpool output packer.
- Fetches densely packed 64-bit words from DRAM, starting at a programmed address.
- Unpacks them into a stream of 64-bit or 48-bit feature chunks for the next layer's input stage.
- Sits between the DRAM read port and the conv/PE input buffer; downstream flow control is valid/ready.

---
 rtl/cnn_pkg.sv | 18 +
 rtl/unpack_shift_buf.sv | 60 ++++++
 rtl/fifo_in_unpack.sv | 128 ++++++++++++
 tb/tb_fifo_in_unpack.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN feature-map read/unpack path.
package cnn_pkg;

  localparam int CHUNK_W64 = 64;
  localparam int CHUNK_W48 = 48;
  localparam int BUF_W     = 128;
  localparam int LVL_W     = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [LVL_W-1:0] chunk_width(input logic mode);
    return mode ? LVL_W'(CHUNK_W48) : LVL_W'(CHUNK_W64);
  endfunction

endpackage

// File: rtl/unpack_shift_buf.sv
// 128-bit LSB-first shift buffer: pops W bits from the bottom, appends a word at the level.
module unpack_shift_buf
  import cnn_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              pop,
  input  logic [LVL_W-1:0]  pop_w,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] head,
  output logic [LVL_W-1:0]  level
);

  logic [BUF_W-1:0] buf_r, shifted_s, buf_nxt_s;
  logic [LVL_W-1:0] level_r, lvl_pop_s, level_nxt_s;

  // Shift out the popped chunk first, then append the returning word at the reduced level
  always_comb begin
    shifted_s   = buf_r;
    lvl_pop_s   = level_r;
    buf_nxt_s   = buf_r;
    level_nxt_s = level_r;
    if (pop) begin
      shifted_s = buf_r >> pop_w;
      lvl_pop_s = level_r - pop_w;
    end else begin
      shifted_s = buf_r;
      lvl_pop_s = level_r;
    end
    if (push) begin
      buf_nxt_s   = shifted_s | ({{(BUF_W-DATA_W){1'b0}}, push_data} << lvl_pop_s);
      level_nxt_s = lvl_pop_s + LVL_W'(DATA_W);
    end else begin
      buf_nxt_s   = shifted_s;
      level_nxt_s = lvl_pop_s;
    end
  end

  // Buffer and level registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_r   <= {BUF_W{1'b0}};
      level_r <= {LVL_W{1'b0}};
    end else if (clear) begin
      buf_r   <= {BUF_W{1'b0}};
      level_r <= {LVL_W{1'b0}};
    end else begin
      buf_r   <= buf_nxt_s;
      level_r <= level_nxt_s;
    end
  end

  assign head  = buf_r[DATA_W-1:0];
  assign level = level_r;

endmodule

// File: rtl/fifo_in_unpack.sv
// DRAM read-side unpacker: fetches packed 64-bit words and streams 64- or 48-bit chunks.
module fifo_in_unpack
  import cnn_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_chunks,
  input  logic              chunk_mode,
  output logic              dram_ren,
  output logic [ADDR_W-1:0] dram_addr,
  input  logic [DATA_W-1:0] dram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam int PROD_W = CNT_W + 7;

  state_e            state_r;
  logic              mode_r, ren_r, inflight_r, done_r;
  logic [CNT_W-1:0]  total_r, issued_r, left_r, issued_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [LVL_W-1:0]  chunk_w_s, start_w_s, level_s;
  logic [DATA_W-1:0] head_s;
  logic              hs_s, last_s, push_s, credit_ok_s;
  logic [9:0]        lvl_nxt_s;

  assign chunk_w_s    = chunk_width(mode_r);
  assign start_w_s    = chunk_width(chunk_mode);
  assign out_valid    = (state_r == RUN) && (level_s >= chunk_w_s) && (left_r != {CNT_W{1'b0}});
  assign hs_s         = out_valid && out_ready;
  assign last_s       = hs_s && (left_r == CNT_W'(1));
  assign push_s       = inflight_r && (state_r == RUN);
  assign issued_nxt_s = issued_r + {{(CNT_W-1){1'b0}}, ren_r};

  // Credit is judged on next cycle's level plus the word requested this cycle
  assign lvl_nxt_s   = 10'(level_s) - (hs_s ? 10'(chunk_w_s) : 10'd0) + (push_s ? 10'd64 : 10'd0);
  assign credit_ok_s = (lvl_nxt_s + (ren_r ? 10'd64 : 10'd0) + 10'd64) <= 10'd128;

  unpack_shift_buf #(.DATA_W(DATA_W)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear | last_s),
    .pop       (hs_s),
    .pop_w     (chunk_w_s),
    .push      (push_s),
    .push_data (dram_rdata),
    .head      (head_s),
    .level     (level_s)
  );

  // Control FSM, address/word counters and registered read request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      mode_r     <= 1'b0;
      ren_r      <= 1'b0;
      inflight_r <= 1'b0;
      done_r     <= 1'b0;
      total_r    <= {CNT_W{1'b0}};
      issued_r   <= {CNT_W{1'b0}};
      left_r     <= {CNT_W{1'b0}};
      addr_r     <= {ADDR_W{1'b0}};
    end else if (clear) begin
      state_r    <= IDLE;
      ren_r      <= 1'b0;
      inflight_r <= 1'b0;
      done_r     <= 1'b0;
      issued_r   <= {CNT_W{1'b0}};
      left_r     <= {CNT_W{1'b0}};
    end else begin
      inflight_r <= ren_r;
      done_r     <= 1'b0;
      issued_r   <= issued_nxt_s;
      if (ren_r) begin
        addr_r <= addr_r + ADDR_W'(1);
      end
      case (state_r)
        IDLE: begin
          ren_r <= 1'b0;
          if (start && (num_chunks == {CNT_W{1'b0}})) begin
            done_r <= 1'b1;
          end else if (start) begin
            state_r  <= RUN;
            mode_r   <= chunk_mode;
            total_r  <= CNT_W'((PROD_W'(num_chunks) * PROD_W'(start_w_s) + PROD_W'(63)) >> 6);
            left_r   <= num_chunks;
            issued_r <= {CNT_W{1'b0}};
            addr_r   <= base_addr;
            ren_r    <= 1'b1;
          end
        end
        RUN: begin
          if (hs_s) begin
            left_r <= left_r - CNT_W'(1);
          end
          if (last_s) begin
            state_r <= IDLE;
            done_r  <= 1'b1;
            ren_r   <= 1'b0;
          end else begin
            ren_r <= (issued_nxt_s < total_r) && credit_ok_s;
          end
        end
        default: begin
          state_r <= IDLE;
          ren_r   <= 1'b0;
        end
      endcase
    end
  end

  assign dram_ren  = ren_r;
  assign dram_addr = addr_r;
  assign busy      = (state_r == RUN);
  assign done      = done_r;
  assign out_data  = mode_r ? {{(DATA_W-CHUNK_W48){1'b0}}, head_s[CHUNK_W48-1:0]} : head_s;

endmodule

// File: tb/tb_fifo_in_unpack.sv
// Scoreboard bench for fifo_in_unpack with a one-cycle-latency DRAM model.
module tb_fifo_in_unpack;

  logic        clk = 1'b0;
  logic        rst_n, clear, start, chunk_mode, out_ready;
  logic [9:0]  base_addr;
  logic [10:0] num_chunks;
  logic        dram_ren, out_valid, busy, done;
  logic [9:0]  dram_addr;
  logic [63:0] dram_rdata, out_data;

  logic [63:0] mem [0:1023];
  logic [63:0] exp_q[$];
  int          addr_q[$];
  int          n_total = 0, n_bad = 0;
  int          rd_cnt, done_cnt = 0, lvl_m, w_m, cyc = 0;
  bit          mon_en = 1'b0, prev_ren, stall_p, hs_m, rdy_bp = 1'b0, rdy_lvl = 1'b1;
  logic [63:0] data_p;
  logic [3:0]  pat = 4'b1001;

  fifo_in_unpack dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .base_addr(base_addr),
    .num_chunks(num_chunks), .chunk_mode(chunk_mode), .dram_ren(dram_ren),
    .dram_addr(dram_addr), .dram_rdata(dram_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // DRAM: data one cycle after the request, junk otherwise
  always @(posedge clk) dram_rdata <= dram_ren ? mem[dram_addr] : 64'hBAD0_BAD0_BAD0_BAD0;

  // Consumer ready: steady level or repeating 1-0-0-1
  always @(posedge clk) begin
    #1;
    out_ready = rdy_bp ? pat[cyc % 4] : rdy_lvl;
    cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_chunk(input int base, input int i, input bit m48);
    int off, wi;
    logic [127:0] two;
    off = i * (m48 ? 48 : 64);
    wi  = off / 64;
    two = {mem[(base + wi + 1) % 1024], mem[(base + wi) % 1024]} >> (off % 64);
    return m48 ? {16'd0, two[47:0]} : two[63:0];
  endfunction

  // Monitor: read addresses, fetch credit, stall stability, output scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (dram_ren) begin
        rd_cnt++;
        if (addr_q.size() == 0) chk("rd_extra", 64'd1, 64'd0);
        else chk("rd_addr", 64'(dram_addr), 64'(addr_q.pop_front()));
        chk("credit", 64'(lvl_m + (prev_ren ? 64 : 0) + 64 <= 128), 64'd1);
      end
      if (stall_p) begin
        chk("stall_v", 64'(out_valid), 64'd1);
        chk("stall_d", out_data, data_p);
      end
      hs_m = out_valid && out_ready;
      if (hs_m) begin
        if (exp_q.size() == 0) chk("out_extra", 64'd1, 64'd0);
        else chk("out_data", out_data, exp_q.pop_front());
      end
      if (done) done_cnt++;
      lvl_m    = lvl_m + (prev_ren ? 64 : 0) - (hs_m ? w_m : 0);
      prev_ren = dram_ren;
      stall_p  = out_valid && !out_ready;
      data_p   = out_data;
    end
  end

  task automatic pulse_start(input int base, input int n, input bit m48);
    @(posedge clk); #1;
    base_addr = 10'(base); num_chunks = 11'(n); chunk_mode = m48; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_xfer(input int base, input int n, input bit m48, input bit bp);
    int words, d0;
    words = (n * (m48 ? 48 : 64) + 63) / 64;
    exp_q.delete(); addr_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(exp_chunk(base, i, m48));
    for (int k = 0; k < words; k++) addr_q.push_back((base + k) % 1024);
    lvl_m = 0; w_m = m48 ? 48 : 64; prev_ren = 1'b0; stall_p = 1'b0; rd_cnt = 0;
    d0 = done_cnt; rdy_bp = bp; rdy_lvl = 1'b1; mon_en = 1'b1;
    pulse_start(base, n, m48);
    @(negedge clk); chk("lat_ren", 64'(dram_ren), 64'd1);
    @(negedge clk); @(negedge clk); chk("lat_val", 64'(out_valid), 64'd1);
    for (int t = 0; t < 400 && done_cnt == d0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("done_once", 64'(done_cnt - d0), 64'd1);
    chk("rd_cnt", 64'(rd_cnt), 64'(words));
    chk("left", 64'(exp_q.size()), 64'd0);
    chk("busy_end", 64'(busy), 64'd0);
    rdy_bp = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
    for (int k = 0; k < 4; k++) mem[238 + k] = 64'hA + 64'(k);
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; chunk_mode = 1'b0;
    base_addr = 10'd0; num_chunks = 11'd0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ren", 64'(dram_ren), 64'd0);
    chk("rst_addr", 64'(dram_addr), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    run_xfer(238, 4, 1'b0, 1'b0);
    run_xfer(10, 4, 1'b1, 1'b0);
    run_xfer(100, 8, 1'b1, 1'b1);
    run_xfer(200, 3, 1'b1, 1'b0);
    chk("odd_lvl", 64'(dut.level_s), 64'd0);
    run_xfer(1023, 2, 1'b0, 1'b0);

    // Zero-length request
    pulse_start(5, 0, 1'b0);
    @(negedge clk);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_ren", 64'(dram_ren), 64'd0);
    chk("zero_busy", 64'(busy), 64'd0);

    // Abort with a read in flight, then restart at address 0
    mon_en = 1'b0; rdy_lvl = 1'b0;
    pulse_start(50, 8, 1'b0);
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    @(negedge clk);
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_valid", 64'(out_valid), 64'd0);
    chk("clr_done", 64'(done), 64'd0);
    run_xfer(0, 2, 1'b0, 1'b0);

    // Reset in the middle of a transfer
    mon_en = 1'b0; rdy_lvl = 1'b0;
    pulse_start(300, 6, 1'b1);
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_ren", 64'(dram_ren), 64'd0);
    chk("mrst_addr", 64'(dram_addr), 64'd0);
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_data", out_data, 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_nodone", 64'(done), 64'd0);
    run_xfer(5, 2, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
